// File: rtl/lcd_controller.sv
// HD44780 character LCD write sequencer: power-up wait, fixed init sequence, then one
// handshaked command/character write at a time with registered RS/DATA/EN timing.
module lcd_controller #(
  parameter int unsigned POWERUP_CYCLES    = 750000,
  parameter int unsigned SETUP_CYCLES      = 2,
  parameter int unsigned EN_HIGH_CYCLES    = 12,
  parameter int unsigned HOLD_CYCLES       = 2,
  parameter int unsigned CMD_WAIT_CYCLES   = 2500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic [7:0] LCD_DATA
);

  typedef enum logic [2:0] {
    StPwrup,
    StSetup,
    StPulse,
    StHold,
    StWait,
    StIdle
  } state_t;

  localparam logic [23:0] PwrLast   = 24'(POWERUP_CYCLES - 1);
  localparam logic [23:0] SetupLast = 24'(SETUP_CYCLES - 1);
  localparam logic [23:0] EnLast    = 24'(EN_HIGH_CYCLES - 1);
  localparam logic [23:0] HoldLast  = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] CmdLast   = 24'(CMD_WAIT_CYCLES - 1);
  localparam logic [23:0] ClearLast = 24'(CLEAR_WAIT_CYCLES - 1);

  state_t      state_q;
  logic [23:0] cnt_q;
  logic [1:0]  init_idx_q;
  logic [23:0] wait_last;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // Clear and home need the long execution wait; only when sent as commands.
  assign wait_last = (!LCD_RS && (LCD_DATA == 8'h01 || LCD_DATA == 8'h02)) ? ClearLast : CmdLast;

  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;
  assign LCD_RW   = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StPwrup;
      cnt_q      <= '0;
      init_idx_q <= '0;
      LCD_EN     <= 1'b0;
      LCD_RS     <= 1'b0;
      LCD_DATA   <= 8'h00;
      cmd_ready  <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      unique case (state_q)
        StPwrup: begin
          if (cnt_q == PwrLast) begin
            cnt_q    <= '0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= init_byte(init_idx_q);
            state_q  <= StSetup;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        StSetup: begin
          if (cnt_q == SetupLast) begin
            cnt_q   <= '0;
            LCD_EN  <= 1'b1;
            state_q <= StPulse;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        StPulse: begin
          if (cnt_q == EnLast) begin
            cnt_q   <= '0;
            LCD_EN  <= 1'b0;
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            cnt_q   <= '0;
            state_q <= StWait;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        StWait: begin
          if (cnt_q == wait_last) begin
            cnt_q <= '0;
            if (init_done || init_idx_q == 2'd3) begin
              init_done <= 1'b1;
              cmd_ready <= 1'b1;
              state_q   <= StIdle;
            end else begin
              init_idx_q <= init_idx_q + 2'd1;
              LCD_RS     <= 1'b0;
              LCD_DATA   <= init_byte(init_idx_q + 2'd1);
              state_q    <= StSetup;
            end
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            LCD_RS    <= cmd_rs;
            LCD_DATA  <= cmd_data;
            cmd_ready <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StSetup;
          end
        end
        default: begin
          state_q <= StPwrup;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_controller.sv
// Randomized self-checking bench for lcd_controller against a timing/sequence model
// derived from write occupancy arithmetic.
module tb_lcd_controller;

  localparam int P_PWR   = 20;
  localparam int P_SETUP = 1;
  localparam int P_EN    = 3;
  localparam int P_HOLD  = 1;
  localparam int P_CMD   = 5;
  localparam int P_CLEAR = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       init_done;
  logic       LCD_ON;
  logic       LCD_BLON;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;
  logic [7:0] LCD_DATA;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Observed EN pulses: rise edge number, RS/DATA at rise, width, RS/DATA at fall.
  int       rise_q[$];
  logic [8:0] rise_sig_q[$];
  int       width_q[$];
  logic [8:0] fall_sig_q[$];
  logic     en_prev = 1'b0;
  int       en_width = 0;

  lcd_controller #(
    .POWERUP_CYCLES   (P_PWR),
    .SETUP_CYCLES     (P_SETUP),
    .EN_HIGH_CYCLES   (P_EN),
    .HOLD_CYCLES      (P_HOLD),
    .CMD_WAIT_CYCLES  (P_CMD),
    .CLEAR_WAIT_CYCLES(P_CLEAR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_rs   (cmd_rs),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .init_done(init_done),
    .LCD_ON   (LCD_ON),
    .LCD_BLON (LCD_BLON),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_RS   (LCD_RS),
    .LCD_DATA (LCD_DATA)
  );

  always #5 clk = ~clk;

  // Edge number since reset release.
  always @(posedge clk) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (reset) begin
      en_prev  = 1'b0;
      en_width = 0;
    end else begin
      if (LCD_EN && !en_prev) begin
        rise_q.push_back(cyc);
        rise_sig_q.push_back({LCD_RS, LCD_DATA});
        en_width = 0;
      end
      if (LCD_EN) en_width = en_width + 1;
      if (!LCD_EN && en_prev) begin
        width_q.push_back(en_width);
        fall_sig_q.push_back({LCD_RS, LCD_DATA});
      end
      en_prev = LCD_EN;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int occ(input logic rs, input logic [7:0] d);
    int w;
    w = (!rs && (d == 8'h01 || d == 8'h02)) ? P_CLEAR : P_CMD;
    return P_SETUP + P_EN + P_HOLD + w;
  endfunction

  task automatic flush_pulses();
    rise_q.delete();
    rise_sig_q.delete();
    width_q.delete();
    fall_sig_q.delete();
  endtask

  task automatic check_pulse(input string tag, input int exp_rise, input logic rs,
                             input logic [7:0] d);
    if (rise_q.size() == 0 || width_q.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_rise"}, rise_q.pop_front(), exp_rise);
      check({tag, "_sig"}, 32'(rise_sig_q.pop_front()), 32'({rs, d}));
      check({tag, "_width"}, width_q.pop_front(), P_EN);
      check({tag, "_held"}, 32'(fall_sig_q.pop_front()), 32'({rs, d}));
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!cmd_ready && n < 500) begin
      step();
      n++;
    end
    if (!cmd_ready) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Release reset, hammer cmd_valid during init, then check the init sequence.
  task automatic run_init(input string tag);
    logic [7:0] bytes[4];
    int load;
    int n;
    bytes[0] = 8'h38;
    bytes[1] = 8'h0C;
    bytes[2] = 8'h01;
    bytes[3] = 8'h06;
    cmd_valid = 1'b1;
    cmd_rs    = 1'($urandom);
    cmd_data  = 8'($urandom);
    reset     = 1'b0;
    n = 0;
    while (!cmd_ready && n < 300) begin
      step();
      if (cmd_ready && !init_done) check({tag, "_ready_early"}, 32'd1, 32'd0);
      cmd_rs   = 1'($urandom);
      cmd_data = 8'($urandom);
      n++;
    end
    cmd_valid = 1'b0;
    load = P_PWR;
    for (int i = 0; i < 4; i++) begin
      check_pulse($sformatf("%s_byte%0d", tag, i), load + P_SETUP, 1'b0, bytes[i]);
      load += occ(1'b0, bytes[i]);
    end
    check({tag, "_ready_cycle"}, cyc, load);
    check({tag, "_init_done"}, init_done, 1'b1);
    check({tag, "_ready"}, cmd_ready, 1'b1);
    check({tag, "_no_extra"}, rise_q.size(), 0);
  endtask

  task automatic do_write(input string tag, input logic rs, input logic [7:0] d);
    int a;
    wait_ready({tag, "_pre"});
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_data  = d;
    step();
    a = cyc;
    cmd_valid = 1'b0;
    cmd_rs    = 1'($urandom);
    cmd_data  = 8'($urandom);
    check({tag, "_rs"}, LCD_RS, rs);
    check({tag, "_data"}, LCD_DATA, d);
    check({tag, "_busy"}, cmd_ready, 1'b0);
    wait_ready(tag);
    check({tag, "_occupancy"}, cyc - a, occ(rs, d));
    check_pulse(tag, a + P_SETUP, rs, d);
  endtask

  initial begin
    logic [7:0] word[3];
    int accepts[3];
    int idx;
    int n;
    logic prev_ready;
    logic rs;
    logic [7:0] d;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h00;
    step();
    step();
    check("rst_en", LCD_EN, 1'b0);
    check("rst_rs", LCD_RS, 1'b0);
    check("rst_rw", LCD_RW, 1'b0);
    check("rst_data", LCD_DATA, 8'h00);
    check("rst_on", LCD_ON, 1'b1);
    check("rst_blon", LCD_BLON, 1'b1);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_init_done", init_done, 1'b0);

    run_init("init");

    do_write("char_n", 1'b1, 8'h6E);
    do_write("cmd_clear", 1'b0, 8'h01);
    do_write("char_01", 1'b1, 8'h01);
    do_write("cmd_home", 1'b0, 8'h02);

    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom);
      d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      do_write($sformatf("rand%0d", i), rs, d);
      repeat ($urandom_range(0, 3)) step();
    end

    // Valid held high; next byte presented after each accept. A new accept needs
    // one idle cycle after the occupancy window because cmd_ready is registered.
    word[0] = 8'h6E;
    word[1] = 8'h75;
    word[2] = 8'h6D;
    wait_ready("b2b_pre");
    idx       = 0;
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = word[0];
    n = 0;
    while (idx < 3 && n < 200) begin
      prev_ready = cmd_ready;
      step();
      if (prev_ready && cmd_valid) begin
        accepts[idx] = cyc;
        idx++;
        if (idx < 3) cmd_data = word[idx];
        else cmd_valid = 1'b0;
      end
      n++;
    end
    cmd_valid = 1'b0;
    check("b2b_accepts", idx, 3);
    wait_ready("b2b_end");
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      check_pulse($sformatf("b2b%0d", i), accepts[0] + P_SETUP + i * (occ(1'b1, 8'h00) + 1),
                  1'b1, word[i]);
    end
    check("b2b_no_extra", rise_q.size(), 0);

    // Reset in the middle of an EN pulse.
    wait_ready("mid_pre");
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = 8'hA5;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!LCD_EN && n < 20) begin
      step();
      n++;
    end
    check("mid_en_high", LCD_EN, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_en", LCD_EN, 1'b0);
    check("mid_rst_data", LCD_DATA, 8'h00);
    check("mid_rst_rs", LCD_RS, 1'b0);
    check("mid_rst_ready", cmd_ready, 1'b0);
    check("mid_rst_init_done", init_done, 1'b0);
    step();
    step();
    flush_pulses();
    run_init("reinit");

    do_write("post_reinit", 1'b1, 8'h41);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
